// File: rtl/md_pkg.sv
// md_pkg: shared definitions for the multiply/divide unit.
//   - md_op_e  : 4-bit operation codes driven on md_op by the EX stage
//   - MD_CNT_W : width of the busy-cycle counter (cycle counts 1..15)
//   - default cycle counts for multiply-class and divide-class operations
// Optional feature macro used by the unit: MD_MADD_EN (enables MADD/MADDU).
package md_pkg;

    typedef enum logic [3:0] {
        MD_MULT  = 4'd0,
        MD_MULTU = 4'd1,
        MD_DIV   = 4'd2,
        MD_DIVU  = 4'd3,
        MD_MTHI  = 4'd4,
        MD_MTLO  = 4'd5,
        MD_MFHI  = 4'd6,
        MD_MFLO  = 4'd7,
        MD_MADD  = 4'd8,
        MD_MADDU = 4'd9
    } md_op_e;

    localparam int MD_CNT_W           = 4;
    localparam int MD_MULT_CYCLES_DEF = 5;
    localparam int MD_DIV_CYCLES_DEF  = 10;

endpackage

// File: rtl/md_calc.sv
// md_calc: combinational 2*WIDTH-bit result calculator for md_unit.
// Optional feature: MD_MADD_EN adds MADD/MADDU ({hi,lo} + product, mod 2^(2W)).
// Ports:
//   op     in  operation code
//   a, b   in  rs / rt operands
//   hi, lo in  current architectural HI/LO (accumulator for MADD/MADDU)
//   res    out {HI,LO} result
//   res_we out result should commit (0 for divide by zero)
//   valid  out op is a start-class (multi-cycle) operation
//   is_div out op uses the divide cycle count
module md_calc
    import md_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  md_op_e             op,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic [WIDTH-1:0]   hi,
    input  logic [WIDTH-1:0]   lo,
    output logic [2*WIDTH-1:0] res,
    output logic               res_we,
    output logic               valid,
    output logic               is_div
);

    logic signed [2*WIDTH-1:0] sa_s;
    logic signed [2*WIDTH-1:0] sb_s;
    logic signed [2*WIDTH-1:0] sprod_s;
    logic        [2*WIDTH-1:0] uprod_s;
    // One extra bit so that most-negative / -1 does not overflow the quotient.
    logic signed [WIDTH:0]     da_s;
    logic signed [WIDTH:0]     db_s;
    logic signed [WIDTH:0]     sq_s;
    logic signed [WIDTH:0]     sr_s;
    logic        [WIDTH-1:0]   uq_s;
    logic        [WIDTH-1:0]   ur_s;
    logic                      b_zero_s;

    assign sa_s     = {{WIDTH{a[WIDTH-1]}}, a};
    assign sb_s     = {{WIDTH{b[WIDTH-1]}}, b};
    assign sprod_s  = sa_s * sb_s;
    assign uprod_s  = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
    assign da_s     = {a[WIDTH-1], a};
    assign db_s     = {b[WIDTH-1], b};
    assign b_zero_s = (b == {WIDTH{1'b0}});

`ifndef MD_MADD_EN
    logic unused_acc_s;
    assign unused_acc_s = ^{hi, lo};
`endif

    // Quotient/remainder; the divider is never evaluated with a zero divisor.
    always_comb begin
        sq_s = {(WIDTH+1){1'b0}};
        sr_s = {(WIDTH+1){1'b0}};
        uq_s = {WIDTH{1'b0}};
        ur_s = {WIDTH{1'b0}};
        if (!b_zero_s) begin
            sq_s = da_s / db_s;
            sr_s = da_s % db_s;
            uq_s = a / b;
            ur_s = a % b;
        end else begin
            sq_s = {(WIDTH+1){1'b0}};
            sr_s = {(WIDTH+1){1'b0}};
            uq_s = {WIDTH{1'b0}};
            ur_s = {WIDTH{1'b0}};
        end
    end

    // Operation decode and result selection.
    always_comb begin
        res    = {(2*WIDTH){1'b0}};
        res_we = 1'b0;
        valid  = 1'b0;
        is_div = 1'b0;
        case (op)
            MD_MULT: begin
                valid  = 1'b1;
                res_we = 1'b1;
                res    = sprod_s;
            end
            MD_MULTU: begin
                valid  = 1'b1;
                res_we = 1'b1;
                res    = uprod_s;
            end
            MD_DIV: begin
                valid  = 1'b1;
                is_div = 1'b1;
                res_we = !b_zero_s;
                res    = {sr_s[WIDTH-1:0], sq_s[WIDTH-1:0]};
            end
            MD_DIVU: begin
                valid  = 1'b1;
                is_div = 1'b1;
                res_we = !b_zero_s;
                res    = {ur_s, uq_s};
            end
`ifdef MD_MADD_EN
            MD_MADD: begin
                valid  = 1'b1;
                res_we = 1'b1;
                res    = {hi, lo} + sprod_s;
            end
            MD_MADDU: begin
                valid  = 1'b1;
                res_we = 1'b1;
                res    = {hi, lo} + uprod_s;
            end
`endif
            default: begin
                res    = {(2*WIDTH){1'b0}};
                res_we = 1'b0;
                valid  = 1'b0;
                is_div = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/md_unit_chk.sv
// md_unit_chk: simulation checker for md_unit, attached by the integrating
// environment. Flags a start or HI/LO write strobe arriving while busy,
// which the D-stage stall logic is expected to prevent.
// Ports: clk, reset (active-low), start, wr_en, busy - all observed only.
module md_unit_chk (
    input logic clk,
    input logic reset,
    input logic start,
    input logic wr_en,
    input logic busy
);

    // No new md instruction may reach EX while an operation is in flight.
    a_no_strobe_when_busy: assert property (
        @(posedge clk) disable iff (!reset) busy |-> !(start || wr_en)
    ) else $error("md_unit_chk: strobe while busy");

endmodule

// File: rtl/md_unit.sv
// md_unit: multi-cycle multiply/divide unit with HI/LO registers (EX stage).
// Optional feature macro: MD_MADD_EN (MADD/MADDU decode, multiply timing).
// Ports:
//   clk       in  pipeline clock, rising edge
//   reset     in  asynchronous active-low reset
//   start     in  one-cycle pulse: EX instruction is MULT/MULTU/DIV/DIVU(/MADD/MADDU)
//   md_op     in  operation code (md_pkg::md_op_e)
//   wr_en     in  EX instruction is MTHI/MTLO
//   a, b      in  forwarded rs / rt operands
//   busy      out operation in progress
//   md_active out start | busy, for the D-stage stall logic
//   hi, lo    out architectural HI/LO registers
module md_unit
    import md_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = MD_MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = MD_DIV_CYCLES_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       md_op,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             md_active,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam logic [MD_CNT_W-1:0] MULT_N = MD_CNT_W'(MULT_CYCLES);
    localparam logic [MD_CNT_W-1:0] DIV_N  = MD_CNT_W'(DIV_CYCLES);

    md_op_e                op_s;
    logic [2*WIDTH-1:0]    calc_res_s;
    logic                  calc_we_s;
    logic                  calc_valid_s;
    logic                  calc_div_s;
    logic                  launch_s;
    logic                  commit_s;
    logic                  mt_ok_s;

    logic                  busy_r;
    logic [MD_CNT_W-1:0]   cnt_r;
    logic [2*WIDTH-1:0]    pend_r;
    logic                  pend_we_r;
    logic [WIDTH-1:0]      hi_r;
    logic [WIDTH-1:0]      lo_r;

    assign op_s = md_op_e'(md_op);

    md_calc #(.WIDTH(WIDTH)) u_calc (
        .op     (op_s),
        .a      (a),
        .b      (b),
        .hi     (hi_r),
        .lo     (lo_r),
        .res    (calc_res_s),
        .res_we (calc_we_s),
        .valid  (calc_valid_s),
        .is_div (calc_div_s)
    );

    // A start with an op that is not start-class is simply dropped.
    assign launch_s = start && !busy_r && calc_valid_s;
    // Last busy cycle: the edge that ends it commits the pending result.
    assign commit_s = busy_r && (cnt_r == MD_CNT_W'(1));
    // start owns the cycle even when its op is invalid, so wr_en alongside it is ignored.
    assign mt_ok_s  = wr_en && !start && !busy_r;

    // Busy flag, cycle counter and pending result.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy_r    <= 1'b0;
            cnt_r     <= {MD_CNT_W{1'b0}};
            pend_r    <= {(2*WIDTH){1'b0}};
            pend_we_r <= 1'b0;
        end else if (busy_r) begin
            if (commit_s) begin
                busy_r <= 1'b0;
                cnt_r  <= {MD_CNT_W{1'b0}};
            end else begin
                cnt_r  <= cnt_r - MD_CNT_W'(1);
            end
        end else if (launch_s) begin
            busy_r    <= 1'b1;
            cnt_r     <= calc_div_s ? DIV_N : MULT_N;
            pend_r    <= calc_res_s;
            pend_we_r <= calc_we_s;
        end else begin
            busy_r <= 1'b0;
        end
    end

    // Architectural HI/LO: result commit or MTHI/MTLO while idle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hi_r <= {WIDTH{1'b0}};
            lo_r <= {WIDTH{1'b0}};
        end else if (commit_s) begin
            if (pend_we_r) begin
                hi_r <= pend_r[2*WIDTH-1:WIDTH];
                lo_r <= pend_r[WIDTH-1:0];
            end else begin
                hi_r <= hi_r;
                lo_r <= lo_r;
            end
        end else if (mt_ok_s) begin
            case (op_s)
                MD_MTHI: hi_r <= a;
                MD_MTLO: lo_r <= a;
                default: begin
                    hi_r <= hi_r;
                    lo_r <= lo_r;
                end
            endcase
        end else begin
            hi_r <= hi_r;
            lo_r <= lo_r;
        end
    end

    assign busy      = busy_r;
    assign md_active = start | busy_r;
    assign hi        = hi_r;
    assign lo        = lo_r;

endmodule

// File: tb/tb_md_unit.sv
module tb_md_unit;
    import md_pkg::*;

    logic        clk;
    logic        reset;
    logic        start;
    logic [3:0]  md_op;
    logic        wr_en;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        md_active;
    logic [31:0] hi;
    logic [31:0] lo;

    int total;
    int bad;

    md_unit dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .md_op     (md_op),
        .wr_en     (wr_en),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .md_active (md_active),
        .hi        (hi),
        .lo        (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issue a start pulse and count busy cycles (bounded at 40).
    task automatic issue(input logic [3:0] op, input logic [31:0] va, input logic [31:0] vb,
                         output int n);
        @(negedge clk);
        md_op = op; a = va; b = vb; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (busy === 1'b1 && n < 40) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic write_reg(input logic [3:0] op, input logic [31:0] v);
        @(negedge clk);
        md_op = op; a = v; wr_en = 1'b1;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic test_reset;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0b exp=0", busy); end
        total++; if (hi !== 32'h0) begin bad++; $display("FAIL reset_hi got=%h exp=0", hi); end
        total++; if (lo !== 32'h0) begin bad++; $display("FAIL reset_lo got=%h exp=0", lo); end
        total++; if (md_active !== 1'b0) begin bad++; $display("FAIL reset_active got=%0b exp=0", md_active); end
    endtask

    task automatic test_mult;
        int n;
        issue(MD_MULT, 32'hFFFFFFFF, 32'h2, n);
        total++; if (n != 5) begin bad++; $display("FAIL mult_busy got=%0d exp=5", n); end
        total++; if (hi !== 32'hFFFFFFFF) begin bad++; $display("FAIL mult_hi got=%h exp=ffffffff", hi); end
        total++; if (lo !== 32'hFFFFFFFE) begin bad++; $display("FAIL mult_lo got=%h exp=fffffffe", lo); end
        issue(MD_MULTU, 32'hFFFFFFFF, 32'h2, n);
        total++; if (n != 5) begin bad++; $display("FAIL multu_busy got=%0d exp=5", n); end
        total++; if (hi !== 32'h00000001) begin bad++; $display("FAIL multu_hi got=%h exp=00000001", hi); end
        total++; if (lo !== 32'hFFFFFFFE) begin bad++; $display("FAIL multu_lo got=%h exp=fffffffe", lo); end
    endtask

    task automatic test_div;
        int n;
        issue(MD_DIV, 32'hFFFFFFF9, 32'h2, n);
        total++; if (n != 10) begin bad++; $display("FAIL div_busy got=%0d exp=10", n); end
        total++; if (lo !== 32'hFFFFFFFD) begin bad++; $display("FAIL div_lo got=%h exp=fffffffd", lo); end
        total++; if (hi !== 32'hFFFFFFFF) begin bad++; $display("FAIL div_hi got=%h exp=ffffffff", hi); end
        issue(MD_DIVU, 32'h7, 32'h2, n);
        total++; if (lo !== 32'h3) begin bad++; $display("FAIL divu_lo got=%h exp=3", lo); end
        total++; if (hi !== 32'h1) begin bad++; $display("FAIL divu_hi got=%h exp=1", hi); end
        issue(MD_DIV, 32'h80000000, 32'hFFFFFFFF, n);
        total++; if (lo !== 32'h80000000) begin bad++; $display("FAIL divovf_lo got=%h exp=80000000", lo); end
        total++; if (hi !== 32'h0) begin bad++; $display("FAIL divovf_hi got=%h exp=0", hi); end
    endtask

    task automatic test_divzero;
        int n;
        write_reg(MD_MTHI, 32'h11);
        write_reg(MD_MTLO, 32'h22);
        issue(MD_DIVU, 32'h7, 32'h0, n);
        total++; if (n != 10) begin bad++; $display("FAIL divz_busy got=%0d exp=10", n); end
        total++; if (hi !== 32'h11) begin bad++; $display("FAIL divz_hi got=%h exp=11", hi); end
        total++; if (lo !== 32'h22) begin bad++; $display("FAIL divz_lo got=%h exp=22", lo); end
    endtask

    task automatic test_mt;
        write_reg(MD_MTHI, 32'h1234);
        total++; if (hi !== 32'h1234) begin bad++; $display("FAIL mthi got=%h exp=1234", hi); end
        total++; if (lo !== 32'h22) begin bad++; $display("FAIL mthi_lo got=%h exp=22", lo); end
        write_reg(MD_MTLO, 32'h5678);
        total++; if (lo !== 32'h5678) begin bad++; $display("FAIL mtlo got=%h exp=5678", lo); end
    endtask

    task automatic test_mtlo_busy;
        int n;
        @(negedge clk);
        md_op = MD_MULT; a = 32'h3; b = 32'h4; start = 1'b1;
        #1;
        total++; if (md_active !== 1'b1) begin bad++; $display("FAIL active_start got=%0b exp=1", md_active); end
        @(negedge clk);
        start = 1'b0;
        md_op = MD_MTLO; a = 32'hDEAD; wr_en = 1'b1;
        @(negedge clk);
        wr_en = 1'b0;
        total++; if (lo !== 32'h5678) begin bad++; $display("FAIL mtlo_busy_lo got=%h exp=5678", lo); end
        n = 1;
        while (busy === 1'b1 && n < 40) begin
            total++; if (md_active !== 1'b1) begin bad++; $display("FAIL active_busy got=%0b exp=1", md_active); end
            n++;
            @(negedge clk);
        end
        total++; if (n != 5) begin bad++; $display("FAIL mtlo_busy_cycles got=%0d exp=5", n); end
        total++; if (lo !== 32'hC) begin bad++; $display("FAIL mtlo_busy_res got=%h exp=c", lo); end
        total++; if (hi !== 32'h0) begin bad++; $display("FAIL mtlo_busy_hi got=%h exp=0", hi); end
    endtask

    task automatic test_invalid_op;
        @(negedge clk);
        md_op = MD_MFHI; a = 32'h9; b = 32'h9; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL invalid_busy got=%0b exp=0", busy); end
        total++; if (lo !== 32'hC) begin bad++; $display("FAIL invalid_lo got=%h exp=c", lo); end
    endtask

    task automatic test_madd;
        int n;
        write_reg(MD_MTHI, 32'h0);
        write_reg(MD_MTLO, 32'hFFFFFFFF);
        issue(MD_MADDU, 32'h1, 32'h1, n);
`ifdef MD_MADD_EN
        total++; if (n != 5) begin bad++; $display("FAIL maddu_busy got=%0d exp=5", n); end
        total++; if (hi !== 32'h1) begin bad++; $display("FAIL maddu_hi got=%h exp=1", hi); end
        total++; if (lo !== 32'h0) begin bad++; $display("FAIL maddu_lo got=%h exp=0", lo); end
`else
        total++; if (n != 0) begin bad++; $display("FAIL maddu_off_busy got=%0d exp=0", n); end
        total++; if (hi !== 32'h0) begin bad++; $display("FAIL maddu_off_hi got=%h exp=0", hi); end
        total++; if (lo !== 32'hFFFFFFFF) begin bad++; $display("FAIL maddu_off_lo got=%h exp=ffffffff", lo); end
`endif
    endtask

    task automatic test_reset_mid;
        write_reg(MD_MTHI, 32'hAAAA);
        @(negedge clk);
        md_op = MD_MULT; a = 32'h5; b = 32'h6; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rstmid_busy got=%0b exp=0", busy); end
        total++; if (hi !== 32'h0) begin bad++; $display("FAIL rstmid_hi got=%h exp=0", hi); end
        total++; if (lo !== 32'h0) begin bad++; $display("FAIL rstmid_lo got=%h exp=0", lo); end
        @(negedge clk);
        reset = 1'b1;
        repeat (8) @(negedge clk);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rstmid_later_busy got=%0b exp=0", busy); end
        total++; if (lo !== 32'h0) begin bad++; $display("FAIL rstmid_later_lo got=%h exp=0", lo); end
    endtask

    initial begin
        total = 0; bad = 0;
        reset = 1'b0; start = 1'b0; wr_en = 1'b0;
        md_op = 4'd0; a = 32'h0; b = 32'h0;
        #2;
        test_reset;
        @(negedge clk);
        reset = 1'b1;
        test_mult;
        test_div;
        test_divzero;
        test_mt;
        test_mtlo_busy;
        test_invalid_op;
        test_madd;
        test_reset_mid;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/md_unit.md
Name: md_unit

Overview:
- Multi-cycle multiply/divide unit with HI/LO registers, sitting in the EX stage of the 5-stage MIPS pipeline.
- Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from EX and serves MFHI/MFLO reads.
- Drives the busy/start indication that the D-stage stall logic uses to hold md-class instructions. It is the producer side of the stall handshake; the hazard detector is the consumer.

Parameters:
- WIDTH, 32, operand and HI/LO width.
- MULT_CYCLES, 5, busy cycles for MULT/MULTU (legal range 1..15).
- DIV_CYCLES, 10, busy cycles for DIV/DIVU (legal range 1..15).

Ports:
- clk  in  1  pipeline clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  EX-stage instruction is MULT/MULTU/DIV/DIVU (MADD/MADDU when MD_MADD_EN is defined); one-cycle pulse.
- md_op  in  4  operation code from the shared package.
- wr_en  in  1  EX-stage instruction is MTHI/MTLO.
- a  in  WIDTH  forwarded rs operand from EX.
- b  in  WIDTH  forwarded rt operand from EX.
- busy  out  1  operation in progress.
- md_active  out  1  combinational start | busy; the stall logic ORs this with the D-stage md-class decode.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.

Behaviour:
- Reset (async, active-low): busy=0, counter=0, hi=0, lo=0, pending result=0. Reset mid-operation aborts the operation; HI/LO read 0.
- Idle, start=1 at edge t0:
  - Latch op and operands; compute the result into the pending register.
  - Load counter with N (MULT_CYCLES or DIV_CYCLES).
  - busy=1 from t0.
- Each edge while busy: counter decrements.
- At edge t0+N: busy falls and the pending result commits to HI/LO in the same edge. New HI/LO are visible from cycle t0+N onward. busy is high for exactly N cycles.
- MULT: signed 64-bit product; HI = upper 32 bits, LO = lower 32 bits. MULTU: unsigned.
- DIV: LO = quotient truncated toward zero; HI = remainder with the sign of the dividend. DIVU: unsigned.
- Divide by zero (b=0): full N-cycle busy; HI and LO are left unchanged.
- DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
- wr_en while idle: MTHI writes hi=a, MTLO writes lo=a at the next edge, zero latency.
- start or wr_en while busy: ignored. The stall logic guarantees this does not occur; assertion-checked in simulation.
- start and wr_en together: start takes priority; wr_en is ignored.
- md_op codes not valid for the asserted strobe: no state change.
- hi/lo are always the architectural values and never show partial results.

Optional Feature:
- MD_MADD_EN defined: md_op additionally decodes MADD/MADDU.
  - The 64-bit {HI,LO} plus the signed (MADD) or unsigned (MADDU) product is computed at start, modulo 2^64.
  - Commits after MULT_CYCLES, with the same busy timing as MULT.
- MD_MADD_EN not defined: these codes are ignored like any other invalid op.

Decomposition:
- Shared package md_pkg: md_op encodings (MD_MULT, MD_MULTU, MD_DIV, MD_DIVU, MD_MTHI, MD_MTLO, MD_MFHI, MD_MFLO, MD_MADD, MD_MADDU) and default cycle-count constants.
- Natural sub-module: md_calc, a combinational 64-bit result calculator (signed/unsigned mul, div, madd) instantiated by md_unit.
- Counter, busy flag and HI/LO registers stay in md_unit.

Test Plan:
- Reset mid-operation: MULT started, reset pulled low at cycle 2 -> busy=0, hi=lo=0 immediately (async); no later commit.
- MULT a=0xFFFFFFFF, b=2 -> busy high 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFE. MULTU with the same operands -> hi=0x00000001, lo=0xFFFFFFFE.
- DIV a=0xFFFFFFF9 (-7), b=2 -> busy high 10 cycles; then lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU a=7, b=2 -> lo=3, hi=1.
- DIVU a=7, b=0 with prior hi=0x11, lo=0x22 -> busy 10 cycles; hi=0x11, lo=0x22 unchanged.
- MTHI a=0x1234 while idle -> hi=0x1234 next cycle. MTLO during busy -> lo unchanged; md_active=1 throughout.
- MD_MADD_EN defined, hi=0, lo=0xFFFFFFFF, MADDU a=1, b=1 -> after 5 cycles hi=1, lo=0.
